// File: rtl/f2d_share_pkg.sv
// Shared types and widths for the float_to_double sharing controller.
// Holds the controller state encoding and the operand/result/counter widths.
package f2d_share_pkg;

    localparam int F32_W = 32;
    localparam int F64_W = 64;
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        ARB    = 3'd0,
        ACCEPT = 3'd1,
        ISSUE  = 3'd2,
        WAIT   = 3'd3,
        RETURN = 3'd4
    } state_t;

endpackage

// File: rtl/f2d_share_ctrl_if.sv
// Requester and converter handshake bundle for f2d_share_ctrl.
// slave = controller side, master = requesters plus converter side.
interface f2d_share_ctrl_if #(
    parameter int N = 4
);
    import f2d_share_pkg::*;

    logic [N*F32_W-1:0] req_a;
    logic [N-1:0]       req_stb;
    logic [N-1:0]       req_ack;
    logic [F64_W-1:0]   res_z;
    logic [N-1:0]       res_stb;
    logic [N-1:0]       res_ack;
    logic [F32_W-1:0]   conv_a;
    logic               conv_a_stb;
    logic               conv_a_ack;
    logic [F64_W-1:0]   conv_z;
    logic               conv_z_stb;
    logic               conv_z_ack;

    modport slave (
        input  req_a, req_stb, res_ack, conv_a_ack, conv_z, conv_z_stb,
        output req_ack, res_z, res_stb, conv_a, conv_a_stb, conv_z_ack
    );

    modport master (
        output req_a, req_stb, res_ack, conv_a_ack, conv_z, conv_z_stb,
        input  req_ack, res_z, res_stb, conv_a, conv_a_stb, conv_z_ack
    );

endinterface

// File: rtl/f2d_share_ctrl_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, modulo N.
// Zero latency; valid is low when no request is set.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        // scan farthest-first so the candidate nearest to ptr is written last
        for (int k = N - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/f2d_share_ctrl.sv
// Round-robin sharing of one non-pipelined float_to_double converter among N requesters.
// One conversion in flight; every channel advances only on its own stb && ack.
module f2d_share_ctrl
    import f2d_share_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    f2d_share_ctrl_if.slave  bus,
    output logic [IDX_W-1:0] grant,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);

    localparam logic [N-1:0] ONE = N'(1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q;
    logic [N-1:0]     req_ack_q, res_stb_q;
    logic [F32_W-1:0] conv_a_q;
    logic [F64_W-1:0] res_z_q;
    logic             conv_a_stb_q, conv_z_ack_q;
    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    logic             acc_xfer, iss_xfer, wait_xfer, ret_xfer;

    rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
        .req   (bus.req_stb),
        .ptr   (ptr_q),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    // only the granted requester's strobes matter once arbitration is over
    assign acc_xfer  = bus.req_stb[grant] && req_ack_q[grant];
    assign iss_xfer  = conv_a_stb_q && bus.conv_a_ack;
    assign wait_xfer = bus.conv_z_stb && conv_z_ack_q;
    assign ret_xfer  = res_stb_q[grant] && bus.res_ack[grant];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ARB;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:     if (pick_vld)  state_d = ACCEPT;
            ACCEPT:  if (acc_xfer)  state_d = ISSUE;
            ISSUE:   if (iss_xfer)  state_d = WAIT;
            WAIT:    if (wait_xfer) state_d = RETURN;
            RETURN:  if (ret_xfer)  state_d = ARB;
            default:                state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= '0;
            grant        <= '0;
            busy         <= 1'b0;
            done_count   <= '0;
            req_ack_q    <= '0;
            res_stb_q    <= '0;
            conv_a_q     <= '0;
            res_z_q      <= '0;
            conv_a_stb_q <= 1'b0;
            conv_z_ack_q <= 1'b0;
        end else begin
            busy <= (state_d != ARB);
            case (state_q)
                ARB: if (pick_vld) begin
                    grant     <= pick_idx;
                    req_ack_q <= ONE << pick_idx;
                    ptr_q     <= (pick_idx == IDX_W'(N - 1)) ? '0 : pick_idx + 1'b1;
                end
                ACCEPT: if (acc_xfer) begin
                    conv_a_q     <= bus.req_a[grant*F32_W +: F32_W];
                    req_ack_q    <= '0;
                    conv_a_stb_q <= 1'b1;
                end
                ISSUE: if (iss_xfer) begin
                    conv_a_stb_q <= 1'b0;
                    conv_z_ack_q <= 1'b1;
                end
                WAIT: if (wait_xfer) begin
                    res_z_q      <= bus.conv_z;
                    conv_z_ack_q <= 1'b0;
                    res_stb_q    <= ONE << grant;
                end
                RETURN: if (ret_xfer) begin
                    res_stb_q  <= '0;
                    done_count <= done_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ack    = req_ack_q;
    assign bus.res_stb    = res_stb_q;
    assign bus.res_z      = res_z_q;
    assign bus.conv_a     = conv_a_q;
    assign bus.conv_a_stb = conv_a_stb_q;
    assign bus.conv_z_ack = conv_z_ack_q;

endmodule

// File: tb/tb_f2d_share_ctrl.sv
// Self-checking bench for f2d_share_ctrl: directed scenarios then a randomized run,
// scored against a requester/converter model kept in the bench.
module tb_f2d_share_ctrl;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  grant;
    logic        busy;
    logic [15:0] done_count;

    always #5 clk = ~clk;

    f2d_share_ctrl_if #(.N(N)) bus ();

    f2d_share_ctrl #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .grant      (grant),
        .busy       (busy),
        .done_count (done_count)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          cv_lat = 1;
    bit          cv_rand = 1'b0;
    logic [31:0] op [N];
    logic [31:0] taken [N];
    logic [63:0] got_z [N];
    bit          pend [N];
    bit          waiting [N];
    int          since [N];
    int          served [N];
    int          posted [N];
    int          order_q [$];
    int          n_done = 0;
    logic [15:0] exp_cnt = '0;
    bit          hold_ack = 1'b0;
    bit          rnd_mode = 1'b0;
    int          rnd_left = 0;

    function automatic logic [63:0] f2d(input logic [31:0] a);
        logic [10:0] e;
        e = {3'b000, a[30:23]} + 11'd896;
        return {a[31], e, a[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] rand_f32();
        logic [7:0] e;
        e = 8'($urandom_range(1, 254));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    function automatic bit outstanding();
        bit o;
        o = 1'b0;
        for (int i = 0; i < N; i++) o = o | pend[i] | waiting[i];
        return o;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // converter: accepts an operand, waits cv_lat cycles, returns the double
    initial begin : conv_model
        int          st;
        int          cnt;
        logic [31:0] a;
        bit          ax, zx;
        st = 0; cnt = 0; a = '0;
        bus.conv_a_ack = 1'b1;
        bus.conv_z_stb = 1'b0;
        bus.conv_z     = '0;
        forever begin
            @(negedge clk);
            ax = bus.conv_a_stb && bus.conv_a_ack;
            zx = bus.conv_z_stb && bus.conv_z_ack;
            if (ax) a = bus.conv_a;
            @(posedge clk);
            #1;
            if (rst) begin
                st = 0;
                bus.conv_a_ack = 1'b1;
                bus.conv_z_stb = 1'b0;
            end else begin
                case (st)
                    0: if (ax) begin
                        bus.conv_a_ack = 1'b0;
                        cnt = cv_rand ? int'($urandom_range(0, 3)) : cv_lat;
                        st = 1;
                    end
                    1: if (cnt == 0) begin
                        bus.conv_z     = f2d(a);
                        bus.conv_z_stb = 1'b1;
                        st = 2;
                    end else cnt--;
                    default: if (zx) begin
                        bus.conv_z_stb = 1'b0;
                        bus.conv_a_ack = 1'b1;
                        st = 0;
                    end
                endcase
            end
        end
    end

    task automatic post(input int i, input logic [31:0] a);
        op[i] = a;
        bus.req_a[32*i +: 32] = a;
        bus.req_stb[i] = 1'b1;
        pend[i] = 1'b1;
        since[i] = 0;
        posted[i]++;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done_count"}, done_count, 0);
        chk({tag, "_req_ack"}, bus.req_ack, 0);
        chk({tag, "_res_stb"}, bus.res_stb, 0);
        chk({tag, "_conv_a_stb"}, bus.conv_a_stb, 0);
        chk({tag, "_conv_z_ack"}, bus.conv_z_ack, 0);
        chk({tag, "_conv_a"}, bus.conv_a, 0);
        chk({tag, "_res_z"}, bus.res_z, 0);
    endtask

    // assert reset asynchronously, check outputs at once, release on a negedge
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk_reset(tag);
        bus.req_stb = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; waiting[i] = 1'b0; since[i] = 0; served[i] = 0; posted[i] = 0;
        end
        order_q.delete();
        exp_cnt = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // one clock: score transfers seen at the coming edge, then react as requesters
    task automatic cycle();
        logic [N-1:0] rx, zx;
        @(negedge clk);
        rx = bus.req_stb & bus.req_ack;
        zx = bus.res_stb & bus.res_ack;
        chk("done_count", done_count, exp_cnt);
        chk("req_ack_onehot", $onehot0(bus.req_ack), 1);
        chk("res_stb_onehot", $onehot0(bus.res_stb), 1);
        for (int i = 0; i < N; i++) begin
            if (rx[i]) taken[i] = op[i];
            if (zx[i]) begin
                chk("res_z", bus.res_z, f2d(taken[i]));
                chk("res_grant", grant, i);
                chk("fair_wait", since[i] <= N - 1, 1);
                got_z[i] = bus.res_z;
                order_q.push_back(i);
                served[i]++;
                n_done++;
                exp_cnt++;
                for (int j = 0; j < N; j++)
                    if (j != i && (pend[j] || waiting[j])) since[j]++;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (rx[i]) begin
                bus.req_stb[i] = 1'b0;
                pend[i] = 1'b0;
                waiting[i] = 1'b1;
            end
            if (zx[i]) waiting[i] = 1'b0;
            if (rnd_mode && rnd_left > 0 && !pend[i] && !waiting[i] && $urandom_range(0, 3) == 0) begin
                post(i, rand_f32());
                rnd_left--;
            end
        end
        bus.res_ack = hold_ack ? '0 : (rnd_mode ? N'($urandom) : '1);
    endtask

    task automatic wait_comp(input int n, input string tag);
        int start, b;
        start = n_done;
        b = 0;
        while (n_done < start + n && b < 3000) begin
            cycle();
            b++;
        end
        chk(tag, n_done - start, n);
    endtask

    initial begin : main
        int          b;
        logic [3:0]  s0;
        logic [63:0] z0;
        bus.req_a = '0;
        bus.req_stb = '0;
        bus.res_ack = '1;
        for (int i = 0; i < N; i++) begin
            op[i] = '0; taken[i] = '0; got_z[i] = '0;
        end
        #2;
        do_reset("reset");

        // single request from requester 2
        cv_lat = 2;
        post(2, 32'h3F800000);
        cycle();
        chk("single_req_ack", bus.req_ack, 4'b0100);
        chk("single_grant", grant, 2);
        chk("single_busy", busy, 1);
        wait_comp(1, "single_done");
        chk("single_res_z", got_z[2], 64'h3FF0000000000000);
        chk("single_owner", order_q[0], 2);
        chk("single_count", done_count, 1);
        chk("single_idle", busy, 0);

        // all four request together straight after reset
        do_reset("reset2");
        post(0, 32'hC0000000);
        for (int i = 1; i < N; i++) post(i, rand_f32());
        wait_comp(4, "all4_done");
        for (int i = 0; i < N; i++) chk("all4_order", order_q[i], i);
        chk("all4_z0", got_z[0], 64'hC000000000000000);
        chk("all4_count", done_count, 4);

        // requester holds res_ack low for 10 cycles while another waits
        hold_ack = 1'b1;
        bus.res_ack = '0;
        post(1, rand_f32());
        post(3, rand_f32());
        b = 0;
        while (bus.res_stb == 0 && b < 200) begin cycle(); b++; end
        chk("hold_res_stb", bus.res_stb, 4'b0010);
        s0 = bus.res_stb;
        z0 = bus.res_z;
        repeat (10) begin
            cycle();
            chk("hold_stb_stable", bus.res_stb, s0);
            chk("hold_z_stable", bus.res_z, z0);
            chk("hold_no_req_ack", bus.req_ack, 0);
            chk("hold_busy", busy, 1);
        end
        hold_ack = 1'b0;
        bus.res_ack = '1;
        wait_comp(2, "hold_done");
        chk("hold_order", order_q[$], 3);

        // slow converter; requester 1 drops stb for 3 cycles inside ACCEPT
        cv_lat = 20;
        post(1, rand_f32());
        cycle();
        chk("drop_ack", bus.req_ack, 4'b0010);
        bus.req_stb[1] = 1'b0;
        repeat (3) begin
            cycle();
            chk("drop_ack_held", bus.req_ack[1], 1);
            chk("drop_no_issue", bus.conv_a_stb, 0);
        end
        bus.req_stb[1] = 1'b1;
        wait_comp(1, "drop_done");
        chk("drop_owner", order_q[$], 1);

        // reset pulsed while the controller waits on the converter
        post(2, rand_f32());
        b = 0;
        while (!bus.conv_z_ack && b < 100) begin cycle(); b++; end
        chk("abort_in_wait", bus.conv_z_ack, 1);
        #1;
        do_reset("abort");
        repeat (25) begin
            cycle();
            chk("abort_no_res", bus.res_stb, 0);
        end
        cv_lat = 1;
        post(3, rand_f32());
        post(0, rand_f32());
        wait_comp(2, "abort_done");
        chk("abort_first", order_q[0], 0);
        chk("abort_second", order_q[1], 3);

        // counter wrap from 0xFFFF
        force dut.done_count = 16'hFFFF;
        #1;
        release dut.done_count;
        exp_cnt = 16'hFFFF;
        post(1, rand_f32());
        wait_comp(1, "wrap_done");
        chk("wrap_count", done_count, 0);

        // randomized traffic, converter latency and res_ack
        rnd_mode = 1'b1;
        cv_rand = 1'b1;
        rnd_left = 80;
        for (int i = 0; i < N; i++) begin served[i] = 0; posted[i] = 0; end
        b = 0;
        while ((rnd_left > 0 || outstanding()) && b < 6000) begin cycle(); b++; end
        chk("rnd_drained", outstanding(), 0);
        for (int i = 0; i < N; i++) chk("rnd_served", served[i], posted[i]);
        rnd_mode = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/f2d_share_ctrl.md
# f2d_share_ctrl

Round-robin controller that shares one `float_to_double` converter among `N` requesters. It accepts a 32-bit single-precision operand from one requester at a time and sequences the operand through the converter's stb/ack handshakes. It returns the 64-bit double result to the same requester and counts completed conversions. It sits between the requester ports and a single, non-pipelined converter instance.

## Interface
- `N`, 4: number of requesters (2..8).
- `IDX_W`, `$clog2(N)`: grant index width.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `req_a`, input, N*32: requester operands; requester i uses `[32*i+31:32*i]`.
- `req_stb`, input, N: operand valid per requester.
- `req_ack`, output, N: operand accept per requester.
- `res_z`, output, 64: result bus, shared by all requesters, qualified by `res_stb`.
- `res_stb`, output, N: result valid, one-hot to the owning requester.
- `res_ack`, input, N: result taken per requester.
- `conv_a`, output, 32: operand to the converter.
- `conv_a_stb`, output, 1: operand valid to the converter.
- `conv_a_ack`, input, 1: converter ready for an operand.
- `conv_z`, input, 64: converter result.
- `conv_z_stb`, input, 1: converter result valid.
- `conv_z_ack`, output, 1: result accept to the converter.
- `grant`, output, IDX_W: index of the current or last-served requester.
- `busy`, output, 1: high in every state except ARB.
- `done_count`, output, 16: number of completed conversions; wraps from 0xFFFF to 0.

## Operation
- Transfer rule on every channel: a word moves on a rising edge where the stb and ack of that channel are both high.
- All outputs are registered.
- FSM states: ARB, ACCEPT, ISSUE, WAIT, RETURN.
- ARB:
  - Pick the first i with `req_stb[i]` high, searching from `ptr` upward modulo N.
  - If a winner exists: `grant<=i`, `req_ack[i]<=1`, `ptr<=(i+1) mod N`, go to ACCEPT.
  - If no request is pending, stay in ARB.
- ACCEPT:
  - On `req_stb[grant] && req_ack[grant]`: latch `conv_a<=req_a[grant]`, `req_ack<=0`, `conv_a_stb<=1`, go to ISSUE.
  - If the requester drops stb, keep ack high and wait indefinitely. A requester must hold stb and data until acked.
- ISSUE: on `conv_a_stb && conv_a_ack`: `conv_a_stb<=0`, `conv_z_ack<=1`, go to WAIT.
- WAIT: on `conv_z_stb && conv_z_ack`: `res_z<=conv_z`, `conv_z_ack<=0`, `res_stb[grant]<=1`, go to RETURN.
- RETURN: on `res_stb[grant] && res_ack[grant]`: `res_stb<=0`, `done_count<=done_count+1` (16-bit wrap), go to ARB.
- Only one conversion is in flight at a time. New requests are not acked until RETURN completes.
- Only `req_stb[grant]`/`res_ack[grant]` are observed; other requesters' inputs are ignored outside ARB.
- Data is passed through unmodified; no arithmetic beyond the pointer increment and the counter.
- Fairness: with all N requesting continuously, the grant order is 0,1,…,N-1,0,…. A requester waits at most N-1 other conversions.

## Timing
- Reset (async assert): state=ARB, `ptr=0`, `grant=0`, `req_ack=0`, `res_stb=0`, `conv_a_stb=0`, `conv_z_ack=0`, `conv_a=0`, `res_z=0`, `done_count=0`, `busy=0`.
- Reset deassertion is synchronised by the integrator. `rst` also drives the converter's reset, so both restart together.
- Reset mid-operation aborts the conversion silently; no result is returned for it.
- Controller overhead with zero-wait partners: ARB 1, ACCEPT 1, ISSUE 1, WAIT 1 + converter latency, RETURN 1.
- A `req_stb` held from cycle 0 sees `req_ack` high in cycle 1. Transfer happens at the end of cycle 1.
- `res_stb` rises 1 cycle after the `conv_z` transfer.
- Back-to-back: the next ARB decision happens in the cycle after the `res_ack` transfer.
- A simultaneous `req_stb` change during ARB is sampled on that edge only.

## Structure
- Package `f2d_share_pkg`:
  - state enum (ARB=0, ACCEPT=1, ISSUE=2, WAIT=3, RETURN=4, 3-bit);
  - `F32_W=32`, `F64_W=64`, `CNT_W=16`.
- Sub-module `rr_pick`: combinational, parameterised by `N`.
  - Inputs: `req[N]`, `ptr[IDX_W]`.
  - Outputs: `valid`, `idx[IDX_W]`.
  - Instantiated once, in ARB decode.
- The converter is instantiated by the parent, not inside this block.

## Test plan
- Single request: req 2, `req_a`=0x3F800000, converter modelled -> `res_stb[2]` only, `res_z`=0x3FF0000000000000, `done_count`=1, `grant`=2.
- All four request at once from reset -> served 0,1,2,3. Results go to the matching `res_stb` bit, e.g. 0xC0000000 -> 0xC000000000000000. `done_count`=4.
- Requester holds `res_ack` low 10 cycles -> `res_stb` and `res_z` stable for all 10 cycles, no new `req_ack` asserted, `busy`=1.
- Converter delays `conv_z_stb` 20 cycles; req 1 drops stb in ACCEPT for 3 cycles -> no transfer until stb returns, then normal completion.
- `rst` pulsed while in WAIT -> all outputs return to their reset values immediately (asynchronously), no `res_stb` pulse. The next request is served by requester 0 first.
- `done_count` preset by 65535 conversions (or forced) -> next completion wraps it to 0.
